// File: rtl/demux_1to4.sv
// demux_1to4: 1-to-4 demultiplexer. Steers the data bit f onto one of four
// output lines selected by {s1, s2}; the unselected lines read 0.
//
// Parameters:
//   REG_OUT - 1: q is registered (1-cycle latency, async active-low reset).
//             0: q is purely combinational; clk and rst_n are ignored.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears q
//   f     - data bit to steer
//   s1    - select MSB
//   s2    - select LSB
//   q     - demux outputs; q[i] = f when {s1,s2} == i, else 0
module demux_1to4 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       f,
  input  logic       s1,
  input  logic       s2,
  output logic [3:0] q
);

  logic [1:0] sel;
  logic [3:0] q_d;

  assign sel = {s1, s2};

  // One-hot-or-zero decode; the default keeps every path assigned.
  always_comb begin
    q_d = 4'b0000;
    unique case (sel)
      2'b00:   q_d[0] = f;
      2'b01:   q_d[1] = f;
      2'b10:   q_d[2] = f;
      2'b11:   q_d[3] = f;
      default: q_d = 4'b0000;
    endcase
  end

  if (REG_OUT) begin : g_reg
    logic [3:0] q_q;

    // Whole vector loads at once, so a select change moves the single 1
    // between bits on one edge with no overlap and no gap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_q <= 4'b0000;
      end else begin
        q_q <= q_d;
      end
    end

    assign q = q_q;
  end else begin : g_comb
    // Clock and reset only exist here to keep the port list uniform.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign q = q_d;
  end

endmodule

// File: tb/tb_demux_1to4.sv
module tb_demux_1to4;

  logic       clk;
  logic       rst_n;
  logic       f;
  logic       s1;
  logic       s2;
  logic [3:0] q_reg;
  logic [3:0] q_comb;

  int tests_run;
  int tests_failed;

  demux_1to4 #(.REG_OUT(1'b1)) u_dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .f     (f),
    .s1    (s1),
    .s2    (s2),
    .q     (q_reg)
  );

  demux_1to4 #(.REG_OUT(1'b0)) u_dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .f     (f),
    .s1    (s1),
    .s2    (s2),
    .q     (q_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [1:0] sv);
    f  = fv;
    s1 = sv[1];
    s2 = sv[0];
  endtask

  logic [1:0] sweep_sel [5];
  logic [3:0] sweep_exp [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sweep_sel[0] = 2'b00; sweep_exp[0] = 4'b0001;
    sweep_sel[1] = 2'b01; sweep_exp[1] = 4'b0010;
    sweep_sel[2] = 2'b10; sweep_exp[2] = 4'b0100;
    sweep_sel[3] = 2'b11; sweep_exp[3] = 4'b1000;
    sweep_sel[4] = 2'b00; sweep_exp[4] = 4'b0001;

    // Reset held with active inputs: registered q stays clear across edges.
    rst_n = 1'b0;
    drive(1'b1, 2'b01);
    #1;
    check("rst_initial", q_reg, 4'b0000);
    check("comb_ignores_rst", q_comb, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold_%0d", i), q_reg, 4'b0000);
    end

    // Release between edges; first edge loads the decode.
    rst_n = 1'b1;
    #1;
    check("rst_release_pre_edge", q_reg, 4'b0000);
    tick();
    check("rst_release_first_edge", q_reg, 4'b0010);

    // Sweep with f = 1.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sweep_sel[i]);
      #1;
      check($sformatf("comb_sweep_%0d", i), q_comb, sweep_exp[i]);
      tick();
      check($sformatf("reg_sweep_%0d", i), q_reg, sweep_exp[i]);
    end

    // Asynchronous reset mid-cycle, no edge in between.
    rst_n = 1'b0;
    #1;
    check("async_rst_clear", q_reg, 4'b0000);
    check("comb_rst_low", q_comb, 4'b0001);
    #1;
    rst_n = 1'b1;
    #1;
    check("async_rst_release_hold", q_reg, 4'b0000);
    check("comb_rst_high", q_comb, 4'b0001);
    tick();
    check("async_rst_reload", q_reg, 4'b0001);

    // Data gating: f = 0 on every select.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i));
      tick();
      check($sformatf("gate_f0_sel%0d", i), q_reg, 4'b0000);
      check($sformatf("comb_gate_f0_sel%0d", i), q_comb, 4'b0000);
    end
    drive(1'b1, 2'b10);
    #1;
    check("gate_f1_pre_edge", q_reg, 4'b0000);
    tick();
    check("gate_f1_sel2", q_reg, 4'b0100);

    // Latency: select change just after an edge is invisible until the next.
    drive(1'b1, 2'b00);
    tick();
    check("lat_start", q_reg, 4'b0001);
    drive(1'b1, 2'b11);
    #1;
    check("lat_hold_a", q_reg, 4'b0001);
    check("comb_lat_new", q_comb, 4'b1000);
    #5;
    check("lat_hold_b", q_reg, 4'b0001);
    tick();
    check("lat_move", q_reg, 4'b1000);

    // Simultaneous change of f and select.
    drive(1'b1, 2'b01);
    tick();
    check("simul_start", q_reg, 4'b0010);
    drive(1'b0, 2'b10);
    tick();
    check("simul_both_change", q_reg, 4'b0000);
    drive(1'b1, 2'b10);
    tick();
    check("simul_f_back", q_reg, 4'b0100);

    // Combinational build against a few patterns with reset toggling.
    rst_n = 1'b0;
    drive(1'b1, 2'b11);
    #1;
    check("comb_rst_toggle_low", q_comb, 4'b1000);
    rst_n = 1'b1;
    drive(1'b1, 2'b01);
    #1;
    check("comb_rst_toggle_high", q_comb, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
